// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with clear sweep and busy scoreboard
// Optional same-cycle write-to-read forwarding: define REGFILE_MP_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rbusy,
    output logic                  ready
);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    logic [AW-1:0]     cnt;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  busy;

    logic write_ok;
    logic set_ok;
    assign write_ok = (state == READY) && we && (wa != '0);
    assign set_ok   = (state == READY) && sb_set && (sb_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= AW'(1);
            ready <= 1'b0;
            busy  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(NREGS - 1)) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: begin
                    // Clear first so a same-cycle set on the same address wins.
                    if (write_ok) busy[wa] <= 1'b0;
                    if (set_ok) busy[sb_addr] <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Register 0 is never written; reads of address 0 are forced to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) regs[cnt] <= '0;
            else if (write_ok) regs[wa] <= wd;
        end
    end

    always_comb begin
        rd    = '0;
        rbusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (state == READY && ra[i*AW +: AW] != '0) begin
                rd[i*XLEN +: XLEN] = regs[ra[i*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
                if (write_ok && ra[i*AW +: AW] == wa) rd[i*XLEN +: XLEN] = wd;
`else
`endif
                rbusy[i] = busy[ra[i*AW +: AW]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed and model-based bench for regfile_mp
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        ready;

    logic        we2;
    logic [3:0]  wa2;
    logic [31:0] wd2;
    logic        sb_set2;
    logic [3:0]  sb_addr2;
    logic [11:0] ra2;
    logic [95:0] rd2;
    logic [2:0]  rbusy2;
    logic        ready2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .sb_set(sb_set), .sb_addr(sb_addr), .ra(ra), .rd(rd),
        .rbusy(rbusy), .ready(ready)
    );

    regfile_mp #(.XLEN(32), .NREGS(16), .NREAD(3)) dut2 (
        .clk(clk), .rst(rst), .we(we2), .wa(wa2), .wd(wd2),
        .sb_set(sb_set2), .sb_addr(sb_addr2), .ra(ra2), .rd(rd2),
        .rbusy(rbusy2), .ready(ready2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the last reset edge: checks the sweep timing of both instances.
    task automatic test_sweep(input string name);
        for (int j = 0; j <= 31; j++) begin
            if (j > 0) tick();
            tests++;
            if (ready !== (j >= 31)) begin
                fails++;
                $display("FAIL %s ready edge %0d: got %b expected %b", name, j, ready, (j >= 31));
            end
            tests++;
            if (ready2 !== (j >= 15)) begin
                fails++;
                $display("FAIL %s ready2 edge %0d: got %b expected %b", name, j, ready2, (j >= 15));
            end
            if (j == 3) begin
                tests++;
                if (rd !== 64'h0 || rbusy !== 2'b00) begin
                    fails++;
                    $display("FAIL %s clear outputs: got rd=%h rbusy=%b expected 0", name, rd, rbusy);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        we = 0; wa = 0; wd = 0; sb_set = 0; sb_addr = 0; ra = {5'd5, 5'd3};
        we2 = 0; wa2 = 0; wd2 = 0; sb_set2 = 0; sb_addr2 = 0; ra2 = '0;
        pulse_reset();
        #1;
        tests++;
        if (ready !== 1'b0 || rd !== 64'h0 || rbusy !== 2'b00) begin
            fails++;
            $display("FAIL reset state: got ready=%b rd=%h rbusy=%b expected 0", ready, rd, rbusy);
        end
        test_sweep("reset");
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a)};
            #1;
            tests++;
            if (rd !== 64'h0 || rbusy !== 2'b00) begin
                fails++;
                $display("FAIL cleared x%0d: got rd=%h rbusy=%b expected 0", a, rd, rbusy);
            end
        end
    endtask

    task automatic test_write();
        we = 1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd5, 5'd5};
        tick();
        we = 0;
        #1;
        tests++;
        if (rd !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL write x5: got %h expected %h", rd, {32'hDEADBEEF, 32'hDEADBEEF});
        end
        we = 1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra = {5'd5, 5'd0};
        tick();
        we = 0;
        #1;
        tests++;
        if (rd !== {32'hDEADBEEF, 32'h0}) begin
            fails++;
            $display("FAIL write x0: got %h expected %h", rd, {32'hDEADBEEF, 32'h0});
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_lane;
`ifdef REGFILE_MP_BYPASS_EN
        exp_lane = 32'h12345678;
`else
        exp_lane = 32'h0;
`endif
        ra = {5'd5, 5'd7};
        we = 1; wa = 5'd7; wd = 32'h12345678;
        #1;
        tests++;
        if (rd[31:0] !== exp_lane || rd[63:32] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL same-cycle x7: got %h expected %h_%h", rd, 32'hDEADBEEF, exp_lane);
        end
        tick();
        we = 0;
        #1;
        tests++;
        if (rd[31:0] !== 32'h12345678) begin
            fails++;
            $display("FAIL after-edge x7: got %h expected %h", rd[31:0], 32'h12345678);
        end
    endtask

    task automatic test_scoreboard();
        ra = {5'd0, 5'd3};
        sb_set = 1; sb_addr = 5'd3;
        #1;
        tests++;
        if (rbusy !== 2'b00) begin
            fails++;
            $display("FAIL busy before set edge: got %b expected 00", rbusy);
        end
        tick();
        sb_set = 0;
        we = 1; wa = 5'd3; wd = 32'h1;
        #1;
        tests++;
        if (rbusy !== 2'b01) begin
            fails++;
            $display("FAIL busy after set: got %b expected 01", rbusy);
        end
        tick();
        we = 0;
        #1;
        tests++;
        if (rbusy !== 2'b00) begin
            fails++;
            $display("FAIL busy after write: got %b expected 00", rbusy);
        end
        sb_set = 1; sb_addr = 5'd3; we = 1; wa = 5'd3; wd = 32'h2;
        tick();
        sb_set = 0; we = 0;
        #1;
        tests++;
        if (rbusy !== 2'b01 || rd[31:0] !== 32'h2) begin
            fails++;
            $display("FAIL set wins: got rbusy=%b rd=%h expected 01 %h", rbusy, rd[31:0], 32'h2);
        end
        sb_set = 1; sb_addr = 5'd0; ra = {5'd0, 5'd0};
        tick();
        sb_set = 0;
        #1;
        tests++;
        if (rbusy !== 2'b00) begin
            fails++;
            $display("FAIL busy x0: got %b expected 00", rbusy);
        end
    endtask

    task automatic test_random();
        logic [31:0] m [16];
        logic [31:0] exp_v;
        logic [3:0]  a;
        for (int k = 0; k < 16; k++) m[k] = 32'h0;
        for (int n = 0; n < 150; n++) begin
            we2 = 1'($urandom_range(0, 1));
            wa2 = 4'($urandom_range(0, 15));
            wd2 = $urandom;
            ra2 = 12'($urandom);
            if (n % 10 == 0) ra2[3:0] = wa2;
            #1;
            for (int p = 0; p < 3; p++) begin
                a = ra2[p*4 +: 4];
                exp_v = (a == 4'd0) ? 32'h0 : m[a];
`ifdef REGFILE_MP_BYPASS_EN
                if (we2 && wa2 != 4'd0 && a == wa2) exp_v = wd2;
`endif
                tests++;
                if (rd2[p*32 +: 32] !== exp_v || rbusy2[p] !== 1'b0) begin
                    fails++;
                    $display("FAIL random n=%0d port %0d x%0d: got %h expected %h", n, p, a, rd2[p*32 +: 32], exp_v);
                end
            end
            tick();
            if (we2 && wa2 != 4'd0) m[wa2] = wd2;
        end
        we2 = 0;
    endtask

    task automatic test_reset_mid_clear();
        pulse_reset();
        for (int k = 0; k < 9; k++) tick();
        pulse_reset();
        #1;
        test_sweep("mid-clear");
        ra = {5'd7, 5'd5};
        #1;
        tests++;
        if (rd !== 64'h0) begin
            fails++;
            $display("FAIL mid-clear regs: got %h expected 0", rd);
        end
    endtask

    task automatic test_reset_ready();
        we = 1; wa = 5'd9; wd = 32'hA5A5A5A5;
        tick();
        wa = 5'd5; wd = 32'h55;
        tick();
        we = 0;
        ra = {5'd9, 5'd5};
        #1;
        tests++;
        if (rd !== {32'hA5A5A5A5, 32'h55}) begin
            fails++;
            $display("FAIL ready writes: got %h expected %h", rd, {32'hA5A5A5A5, 32'h55});
        end
        pulse_reset();
        #1;
        test_sweep("ready-reset");
        tests++;
        if (rd !== 64'h0) begin
            fails++;
            $display("FAIL ready-reset regs: got %h expected 0", rd);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_write();
        test_bypass();
        test_scoreboard();
        test_random();
        test_reset_mid_clear();
        test_reset_ready();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
